// File: rtl/receiver.sv
// UART 8N1 receiver: synchronises RXD, samples each bit at mid-bit using CLKS_PER_BIT
// oversampling, and hands bytes to the host with a level ready / acknowledge handshake.
`timescale 1ns/1ps
module receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       data_ready,
  input  logic       rd_ack,
  output logic       rd_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             ready_q, ready_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             rx_fall;
  logic             half_hit, bit_hit;

  // Synchroniser flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_fall  = prev_q & ~sync2_q;
  assign half_hit = (cnt_q == HALF_LAST);
  assign bit_hit  = (cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_fall) state_d = START;
      START:   if (half_hit) state_d = sync2_q ? IDLE : DATA;
      DATA:    if (bit_hit && (idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;

    // An acknowledge only counts while a byte is pending; a good stop below overrides ready.
    if (rd_ack && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
      end
      START: begin
        if (half_hit) begin
          cnt_d = '0;
          idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_hit) begin
          cnt_d          = '0;
          shift_d[idx_q] = sync2_q;
          idx_d          = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_hit) begin
          cnt_d = '0;
          if (sync2_q) begin
            rx_data_d = shift_q;
            ready_d   = 1'b1;
            if (ready_q && !rd_ack) ovr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
        idx_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign data_ready = ready_q;
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule
